pipe_stall_scheduler: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined CPU.
- Merges three event sources into one set of pipeline-register controls:
  - the load-use hazard request from the hazard detection unit;
  - the taken-branch flush from MEM;
  - occupancy of the multi-cycle multiply/divide unit.
- Owns the mul/div unit's start/busy/done FSM and a stall-cycle performance counter.
- Sits between the hazard detection unit and the PC / IF/ID / ID/EX / EX/MEM registers.

---
 rtl/pipe_stall_scheduler.sv | 139 +++++++++++++
 tb/tb_pipe_stall_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_scheduler
// Brief    : Merges load-use, branch-flush and mul/div occupancy into pipeline
//            register controls; owns the mul/div FSM and a stall counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stall_scheduler #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ld_hazard_i,
    input  logic        branch_taken_i,
    input  logic        ex_md_start_i,
    input  logic        ex_md_div_i,
    input  logic        id_md_op_i,
    input  logic        id_reads_hilo_i,
    output logic        PC_write_o,
    output logic        IFID_write_o,
    output logic        IFID_flush_o,
    output logic        IDEXE_bubble_o,
    output logic        EXMEM_flush_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic        hilo_we_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_MUL_LOAD  = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_LOAD  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      c_STALL_MAX = 16'hFFFF;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;

    logic               w_md_accept;
    logic               w_md_hz;
    logic               w_stall;

    // A start squashed by a taken branch never enters the unit.
    assign w_md_accept = (state_q == ST_IDLE) & ex_md_start_i & ~branch_taken_i;

    // HI/LO consumers wait through DONE since HI/LO is written on DONE->IDLE.
    assign w_md_hz = (id_reads_hilo_i | id_md_op_i) &
                     ((state_q != ST_IDLE) | (ex_md_start_i & ~branch_taken_i));

    assign w_stall = ld_hazard_i | w_md_hz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_md_accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = ex_md_div_i ? c_DIV_LOAD : c_MUL_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (~branch_taken_i & w_stall & (stall_cnt_q != c_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEXE_bubble_o = 1'b0;
        EXMEM_flush_o  = 1'b0;
        md_busy_o      = 1'b0;
        md_done_o      = 1'b0;
        if (rst_i) begin
            PC_write_o     = 1'b0;
            IFID_write_o   = 1'b0;
            IFID_flush_o   = 1'b1;
            IDEXE_bubble_o = 1'b1;
            EXMEM_flush_o  = 1'b1;
        end else begin
            md_busy_o = (state_q != ST_IDLE);
            md_done_o = (state_q == ST_DONE);
            if (branch_taken_i) begin
                IFID_flush_o   = 1'b1;
                IDEXE_bubble_o = 1'b1;
                EXMEM_flush_o  = 1'b1;
            end else if (w_stall) begin
                PC_write_o     = 1'b0;
                IFID_write_o   = 1'b0;
                IDEXE_bubble_o = 1'b1;
            end
        end
    end

    assign hilo_we_o   = md_done_o;
    assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stall_scheduler
// Brief    : Random and directed stimulus against a countdown reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stall_scheduler;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ld_hazard_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        ex_md_start_i = 1'b0;
    logic        ex_md_div_i = 1'b0;
    logic        id_md_op_i = 1'b0;
    logic        id_reads_hilo_i = 1'b0;
    logic        PC_write_o, IFID_write_o, IFID_flush_o, IDEXE_bubble_o;
    logic        EXMEM_flush_o, md_busy_o, md_done_o, hilo_we_o;
    logic [15:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    // Reference state: cycles left until the unit is free again (BUSY + DONE).
    int m_rem = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    pipe_stall_scheduler #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (6)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ld_hazard_i    (ld_hazard_i),
        .branch_taken_i (branch_taken_i),
        .ex_md_start_i  (ex_md_start_i),
        .ex_md_div_i    (ex_md_div_i),
        .id_md_op_i     (id_md_op_i),
        .id_reads_hilo_i(id_reads_hilo_i),
        .PC_write_o     (PC_write_o),
        .IFID_write_o   (IFID_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEXE_bubble_o (IDEXE_bubble_o),
        .EXMEM_flush_o  (EXMEM_flush_o),
        .md_busy_o      (md_busy_o),
        .md_done_o      (md_done_o),
        .hilo_we_o      (hilo_we_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        bit busy;
        busy = (m_rem > 0);
        return ld_hazard_i | ((id_reads_hilo_i | id_md_op_i) &
                              (busy | (ex_md_start_i & ~branch_taken_i)));
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            m_rem = 0;
            m_cnt = 0;
        end else begin
            if (!branch_taken_i && model_stall() && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (ex_md_start_i && !branch_taken_i)
                m_rem = (ex_md_div_i ? DIV_LAT : MUL_LAT) + 1;
        end
    end

    // {PC_write, IFID_write, IFID_flush, IDEXE_bubble, EXMEM_flush, busy, done, hilo_we}
    always @(negedge clk) begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        bit done;
        done = (m_rem == 1);
        if (rst_i)                exp_v = 8'b00111000;
        else begin
            if (branch_taken_i)   exp_v[7:3] = 5'b11111;
            else if (model_stall()) exp_v[7:3] = 5'b00010;
            else                  exp_v[7:3] = 5'b11000;
            exp_v[2:0] = {m_rem > 0, done, done};
        end
        act_v = {PC_write_o, IFID_write_o, IFID_flush_o, IDEXE_bubble_o,
                 EXMEM_flush_o, md_busy_o, md_done_o, hilo_we_o};
        chk("ctrl_vec", {24'd0, act_v}, {24'd0, exp_v});
        chk("stall_cnt", {16'd0, stall_cnt_o}, m_cnt);
    end

    task automatic cyc(input logic r, input logic ld, input logic br, input logic st,
                       input logic dv, input logic op, input logic rd);
        @(posedge clk);
        #1;
        rst_i = r; ld_hazard_i = ld; branch_taken_i = br; ex_md_start_i = st;
        ex_md_div_i = dv; id_md_op_i = op; id_reads_hilo_i = rd;
        #2;
    endtask

    initial begin
        int base;
        int n_stall;
        int done_at;
        int adv_at;
        int n_busy;
        int n_done;
        bit pc_ok;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_busy_before_rst", {31'd0, md_busy_o}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_pc", {31'd0, PC_write_o}, 32'd0);
        chk("lit_rst_flushes", {29'd0, IFID_flush_o, IDEXE_bubble_o, EXMEM_flush_o}, 32'd7);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("lit_rst_busy", {31'd0, md_busy_o}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_post_rst_pc", {31'd0, PC_write_o}, 32'd1);
        chk("lit_post_rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            n_done += int'(md_done_o);
        end
        chk("lit_no_done_after_rst", n_done, 0);

        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("lit_ld_ctrl", {29'd0, PC_write_o, IFID_write_o, IDEXE_bubble_o}, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_ld_cnt", {16'd0, stall_cnt_o}, 32'd1);

        base = stall_cnt_o;
        cyc(0, 0, 0, 1, 0, 0, 1);
        n_stall = int'(!PC_write_o);
        done_at = -1;
        adv_at = -1;
        for (int i = 1; i <= 20 && adv_at < 0; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            if (md_done_o && hilo_we_o) done_at = i;
            if (PC_write_o) adv_at = i;
            else n_stall++;
        end
        chk("lit_mul_stalls", n_stall, 6);
        chk("lit_mul_done_at", done_at, 5);
        chk("lit_mul_adv_at", adv_at, 6);
        chk("lit_mul_cnt", {16'd0, stall_cnt_o}, base + 6);

        base = stall_cnt_o;
        cyc(0, 0, 0, 1, 1, 0, 0);
        pc_ok = PC_write_o;
        n_busy = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            n_busy += int'(md_busy_o);
            pc_ok &= PC_write_o;
        end
        chk("lit_div_busy", n_busy, 33);
        chk("lit_div_pc", {31'd0, pc_ok}, 32'd1);
        chk("lit_div_cnt", {16'd0, stall_cnt_o}, base);

        cyc(0, 0, 1, 1, 0, 0, 0);
        chk("lit_br_start_ctrl", {28'd0, PC_write_o, IFID_flush_o, IDEXE_bubble_o, EXMEM_flush_o}, 32'hF);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("lit_br_start_busy", {31'd0, md_busy_o}, 32'd0);

        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1);
        base = stall_cnt_o;
        chk("lit_br_busy_flush", {29'd0, PC_write_o, IFID_flush_o, EXMEM_flush_o}, 32'd7);
        done_at = -1;
        for (int i = 2; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            if (i == 2) chk("lit_br_busy_cnt", {16'd0, stall_cnt_o}, base);
            if (md_done_o && done_at < 0) done_at = i;
        end
        chk("lit_br_busy_done_at", done_at, 5);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
